// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// -----------------------------------------------------------------------------
// jellyvl_etherneco_synctimer_scheduler
//
// Master-side sequencer for the etherneco sync-timer ring. A free-running
// period counter produces launch ticks. On each tick (when idle-waiting) the
// master time and renew/correct flags are latched and offered to the packet
// transmitter. After the handshake, the returning response frame is awaited
// under timeout supervision. Outcome statistics and a synced flag are kept
// for the register block.
//
// State table:
//   state | meaning
//   IDLE  | scheduler stopped, period counter frozen
//   WAIT  | running, waiting for next period tick
//   REQ   | command offered to transmitter (m_cmd_valid=1)
//   RESP  | command sent, waiting for response or timeout
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   enable               run scheduler
//   param_period         cycles between launches (<2 treated as 2)
//   param_timeout        response timeout in cycles (0 treated as 1)
//   param_renew_count    number of initial commands with renew flag
//   current_time         master free-running time
//   m_cmd_time/flags     command payload, stable while m_cmd_valid
//   m_cmd_valid/ready    command handshake to the transmitter
//   res_rx_end/error     response frame completion / error
//   busy                 state is REQ or RESP
//   synced               a non-renew command completed OK since start
//   stat_*               saturating statistics counters
// -----------------------------------------------------------------------------
module jellyvl_etherneco_synctimer_scheduler #(
    parameter int TIMER_WIDTH   = 64,
    parameter int PERIOD_WIDTH  = 32,
    parameter int TIMEOUT_WIDTH = 24,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [PERIOD_WIDTH-1:0]  param_period,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    input  logic [7:0]               param_renew_count,
    input  logic [TIMER_WIDTH-1:0]   current_time,
    output logic [TIMER_WIDTH-1:0]   m_cmd_time,
    output logic [7:0]               m_cmd_flags,
    output logic                     m_cmd_valid,
    input  logic                     m_cmd_ready,
    input  logic                     res_rx_end,
    input  logic                     res_rx_error,
    output logic                     busy,
    output logic                     synced,
    output logic [COUNT_WIDTH-1:0]   stat_sent,
    output logic [COUNT_WIDTH-1:0]   stat_timeout,
    output logic [COUNT_WIDTH-1:0]   stat_error,
    output logic [COUNT_WIDTH-1:0]   stat_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [PERIOD_WIDTH-1:0]  period_cnt;
    logic [PERIOD_WIDTH-1:0]  period_load;
    logic [TIMEOUT_WIDTH-1:0] timeout_cnt;
    logic [TIMEOUT_WIDTH-1:0] timeout_load;
    logic [7:0]               renew_remain;
    logic                     sent_renew;

    logic tick;
    logic handshake;
    logic resp_ok;
    logic resp_err;
    logic resp_to;
    logic resp_done;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    // Counter reload value is period-1, with the period clamped to >= 2.
    assign period_load  = (param_period[PERIOD_WIDTH-1:1] == '0) ? PERIOD_WIDTH'(1)
                                                                 : param_period - PERIOD_WIDTH'(1);
    assign timeout_load = (param_timeout == '0) ? TIMEOUT_WIDTH'(1) : param_timeout;

    assign tick      = (state != ST_IDLE) && (period_cnt == '0);
    assign handshake = (state == ST_REQ) && m_cmd_ready;
    assign resp_ok   = (state == ST_RESP) && res_rx_end && !res_rx_error;
    assign resp_err  = (state == ST_RESP) && res_rx_error;
    // A response arriving in the expiry cycle wins over the timeout.
    assign resp_to   = (state == ST_RESP) && !res_rx_end && !res_rx_error
                       && (timeout_cnt == TIMEOUT_WIDTH'(1));
    assign resp_done = resp_ok || resp_err || resp_to;

    // Valid is masked by reset so it drops in the reset cycle itself.
    assign m_cmd_valid = (state == ST_REQ) && !reset;
    assign busy        = (state == ST_REQ) || (state == ST_RESP);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable) state_next = ST_WAIT;
            ST_WAIT: begin
                if (!enable)   state_next = ST_IDLE;
                else if (tick) state_next = ST_REQ;
            end
            ST_REQ:  if (m_cmd_ready) state_next = ST_RESP;
            ST_RESP: if (resp_done) state_next = enable ? ST_WAIT : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt   <= '0;
            timeout_cnt  <= '0;
            renew_remain <= '0;
            sent_renew   <= 1'b0;
            m_cmd_time   <= '0;
            m_cmd_flags  <= '0;
            synced       <= 1'b0;
            stat_sent    <= '0;
            stat_timeout <= '0;
            stat_error   <= '0;
            stat_overrun <= '0;
        end else begin
            // Period ticks run independently of the command state.
            if (state == ST_IDLE) begin
                if (enable) period_cnt <= period_load;
            end else if (period_cnt == '0) begin
                period_cnt <= period_load;
            end else begin
                period_cnt <= period_cnt - PERIOD_WIDTH'(1);
            end

            if (state == ST_IDLE && enable) begin
                renew_remain <= param_renew_count;
                synced       <= 1'b0;
            end

            if (state == ST_WAIT && enable && tick) begin
                m_cmd_time  <= current_time;
                m_cmd_flags <= {6'b0, (renew_remain != 8'd0), 1'b1};
            end

            if (handshake) begin
                stat_sent   <= sat_inc(stat_sent);
                timeout_cnt <= timeout_load;
                sent_renew  <= m_cmd_flags[1];
                if (renew_remain != 8'd0) renew_remain <= renew_remain - 8'd1;
            end

            if (state == ST_RESP && timeout_cnt != '0) begin
                timeout_cnt <= timeout_cnt - TIMEOUT_WIDTH'(1);
            end

            if (resp_ok && !sent_renew) synced <= 1'b1;
            if (resp_err) stat_error   <= sat_inc(stat_error);
            if (resp_to)  stat_timeout <= sat_inc(stat_timeout);

            // Ticks during an outstanding command are dropped, not queued.
            if (tick && busy) stat_overrun <= sat_inc(stat_overrun);
        end
    end

endmodule
